fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Control and storage stage of the 8-entry synchronous FIFO. Registers read/write requests into the 3-bit FIFO state and tracks the 4-bit occupancy count. Maintains head/tail pointers into an 8×32 register file and drives the read data register. Its `state` and `data_count` outputs feed the FIFO output-logic stage directly, which derives full/empty and the handshake flags.

## Interface
- `DATA_WIDTH`, 32, width of each stored word
- `clk`  in  1  system clock; all state updates on rising edge
- `reset_n`  in  1  reset, asynchronous and active-low
- `wr_en`  in  1  write request, sampled on rising edge of `clk`
- `rd_en`  in  1  read request, sampled on rising edge of `clk`
- `d_in`  in  DATA_WIDTH  write data, sampled with `wr_en`
- `d_out`  out  DATA_WIDTH  read data register
- `state`  out  3  current FIFO state, registered
- `data_count`  out  4  entries held, 0..8, registered
- `head`  out  3  read pointer
- `tail`  out  3  write pointer

## Operation
- State encoding:
  - INIT = 000
  - WRITE = 001
  - WR_ERR = 010
  - NO_OP = 011
  - READ = 100
  - RD_ERR = 101
- Next state is computed from `wr_en`, `rd_en` and the current `data_count`. It is the same from every state, including INIT.
  - `wr_en`=1, `rd_en`=0: WRITE if `data_count` < 8, else WR_ERR.
  - `wr_en`=0, `rd_en`=1: READ if `data_count` > 0, else RD_ERR.
  - Both 0 or both 1: NO_OP. A simultaneous request performs no transfer.
- INIT is entered only by reset. It is left on the first clock edge after `reset_n` deasserts.
- Unused codes 110/111 are unreachable. If present, the next edge applies the normal rules above.
- Datapath action on the same edge that enters the state:
  - WRITE: `mem[tail]` <= `d_in`; `tail` <= `tail`+1; `data_count` <= `data_count`+1.
  - READ: `d_out` <= `mem[head]`; `head` <= `head`+1; `data_count` <= `data_count`−1.
  - WR_ERR, RD_ERR, NO_OP: memory, pointers, count and `d_out` all hold.
- Pointers are 3 bits and wrap naturally: 7+1 → 0.
- `data_count` never exceeds 8 and never underflows, because the error states block both cases.
- `d_out` holds its last read value until the next READ.
- Memory contents are not reset. Locations are only read after being written.

## Timing
- Reset (`reset_n`=0, asynchronous, immediate) sets:
  - `state`=INIT(000)
  - `data_count`=0
  - `head`=0
  - `tail`=0
  - `d_out`=0
- Reset asserted mid-operation aborts any transfer. All of the above take reset values without waiting for a clock edge.
- Latency is one cycle. A request sampled at edge N is reflected at edge N in `state`, `data_count` and the pointers, and is visible in the following cycle.
- `state` describes the operation just performed. `data_count` is the post-operation occupancy. The output stage therefore sees a consistent pair, e.g. WRITE with `data_count`=8 means the write just filled the FIFO.
- For READ, `d_out` is valid in the cycle after the edge that entered READ.
- Back-to-back requests on every cycle are supported, with no idle cycle required.
- Full/empty decisions always use the registered `data_count` from before the edge, never the value being updated.

## Test plan
- Reset check: assert `reset_n`=0 between clock edges, with the FIFO part-filled.
  - Required: `state`=000, `data_count`=0, `head`=`tail`=0, `d_out`=0 immediately, without waiting for a clock edge.
- Fill and overflow: write 0x11..0x88 on 8 consecutive cycles.
  - Required: `state`=001 each cycle, `data_count` 1..8, `tail` ends at 0.
  - Then a 9th write: required `state`=010, `data_count` stays 8, `tail` stays 0.
- Drain and underflow: from full, read on 8 consecutive cycles.
  - Required: `d_out`=0x11..0x88 in order, `state`=100, `data_count` 7..0.
  - Then a 9th read: required `state`=101, `data_count`=0, `d_out` holds 0x88.
- Simultaneous and idle: with `data_count`=3, set `wr_en`=`rd_en`=1, then both 0.
  - Required: `state`=011 both cycles; `data_count`, `head`, `tail` unchanged.
- Wrap-around: with `head`=`tail`=6 and `data_count`=0, interleave write, read, write, read with 0xA..0xD.
  - Required: pointers pass 7→0, `d_out`=0xA then 0xC, `data_count` alternates 1/0.
- Reset mid-operation: assert `reset_n`=0 during a burst of writes with `data_count`=5.
  - Required: immediate INIT with count 0 and pointers 0.
  - After release, the first write stores at `tail`=0 and gives `data_count`=1.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Control and storage stage of the 8-entry FIFO: request decode into a
// registered state, occupancy count, head/tail pointers and read-data register.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [2:0]            state,
    output logic [3:0]            data_count,
    output logic [2:0]            head,
    output logic [2:0]            tail
);

    localparam logic [2:0] S_INIT   = 3'b000;
    localparam logic [2:0] S_WRITE  = 3'b001;
    localparam logic [2:0] S_WR_ERR = 3'b010;
    localparam logic [2:0] S_NO_OP  = 3'b011;
    localparam logic [2:0] S_READ   = 3'b100;
    localparam logic [2:0] S_RD_ERR = 3'b101;

    localparam logic [3:0] DEPTH = 4'd8;

    typedef struct packed {
        logic wr;
        logic rd;
    } req_t;

    req_t                  req;
    logic [2:0]            next_state;
    logic                  do_wr;
    logic                  do_rd;
    logic [DATA_WIDTH-1:0] mem [8];

    assign req = '{wr: wr_en, rd: rd_en};

    // Decode ignores the current state entirely; full/empty use the
    // pre-edge count so the error states guard the count range.
    always_comb begin
        next_state = S_NO_OP;
        unique case ({req.wr, req.rd})
            2'b10:   next_state = (data_count < DEPTH)  ? S_WRITE : S_WR_ERR;
            2'b01:   next_state = (data_count != 4'd0)  ? S_READ  : S_RD_ERR;
            default: next_state = S_NO_OP;
        endcase
    end

    assign do_wr = (next_state == S_WRITE);
    assign do_rd = (next_state == S_READ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_INIT;
            data_count <= 4'd0;
            head       <= 3'd0;
            tail       <= 3'd0;
            d_out      <= '0;
        end else begin
            state <= next_state;
            if (do_wr) begin
                tail       <= tail + 3'd1;
                data_count <= data_count + 4'd1;
            end
            if (do_rd) begin
                d_out      <= mem[head];
                head       <= head + 3'd1;
                data_count <= data_count - 4'd1;
            end
        end
    end

    // Storage is deliberately not reset; entries are only read after a write.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[tail] <= d_in;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized plus directed bench for fifo_ctrl against a queue-based model.
module tb_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [2:0]  state;
    logic [3:0]  data_count;
    logic [2:0]  head;
    logic [2:0]  tail;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q[$];
    int          exp_head;
    int          exp_tail;
    logic [31:0] exp_dout;
    int          exp_state;

    fifo_ctrl #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .d_in      (d_in),
        .d_out     (d_out),
        .state     (state),
        .data_count(data_count),
        .head      (head),
        .tail      (tail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(exp_state));
        chk({tag, ".count"}, 32'(data_count), 32'(q.size()));
        chk({tag, ".head"},  32'(head), 32'(exp_head));
        chk({tag, ".tail"},  32'(tail), 32'(exp_tail));
        chk({tag, ".dout"},  d_out, exp_dout);
    endtask

    task automatic model_reset();
        q.delete();
        exp_head  = 0;
        exp_tail  = 0;
        exp_dout  = 32'h0;
        exp_state = 0;
    endtask

    // One request cycle; the model decides from occupancy before the edge.
    task automatic step(input string tag, input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        if (w && !r) begin
            if (q.size() < 8) begin
                q.push_back(d);
                exp_tail  = (exp_tail + 1) % 8;
                exp_state = 1;
            end else begin
                exp_state = 2;
            end
        end else if (!w && r) begin
            if (q.size() > 0) begin
                exp_dout  = q.pop_front();
                exp_head  = (exp_head + 1) % 8;
                exp_state = 4;
            end else begin
                exp_state = 5;
            end
        end else begin
            exp_state = 3;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset between edges while a write is being requested; outputs must
    // clear at once, then INIT must be left on the first edge after release.
    task automatic async_reset(input string tag);
        @(negedge clk);
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        d_in    = $urandom;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".imm"});
        wr_en = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp_state = 3;
        check_all({tag, ".exit"});
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = 32'h0;
        model_reset();
        #3;
        check_all("por");
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp_state = 3;
        check_all("por.exit");

        // Part-fill, then reset between edges
        for (int i = 0; i < 3; i++) step("pfill", 1'b1, 1'b0, $urandom);
        async_reset("rst_part");

        // Fill and overflow
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 32'(i * 17));
        chk("fill.tail_wrapped", 32'(tail), 32'd0);
        step("ovf", 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("ovf.state", 32'(state), 32'd2);

        // Drain and underflow
        for (int i = 1; i <= 8; i++) begin
            step("drain", 1'b0, 1'b1, 32'h0);
            chk("drain.order", d_out, 32'(i * 17));
        end
        step("udf", 1'b0, 1'b1, 32'h0);
        chk("udf.hold", d_out, 32'h88);

        // Simultaneous and idle with three entries
        for (int i = 0; i < 3; i++) step("pre3", 1'b1, 1'b0, $urandom);
        step("both", 1'b1, 1'b1, 32'h1234);
        step("idle", 1'b0, 1'b0, 32'h5678);
        chk("idle.count", 32'(data_count), 32'd3);

        // Align pointers to 6 with the FIFO empty, then wrap
        for (int i = 0; i < 3; i++) step("empty", 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step("align", 1'b1, 1'b0, $urandom);
            step("align", 1'b0, 1'b1, 32'h0);
        end
        chk("wrap.start_head", 32'(head), 32'd6);
        step("wrap", 1'b1, 1'b0, 32'hA);
        step("wrap", 1'b0, 1'b1, 32'hB);
        chk("wrap.d0", d_out, 32'hA);
        step("wrap", 1'b1, 1'b0, 32'hC);
        chk("wrap.tail0", 32'(tail), 32'd0);
        step("wrap", 1'b0, 1'b1, 32'hD);
        chk("wrap.d1", d_out, 32'hC);

        // Reset mid write burst with five entries, then first write lands at 0
        for (int i = 0; i < 5; i++) step("burst", 1'b1, 1'b0, $urandom);
        async_reset("rst_mid");
        step("post", 1'b1, 1'b0, 32'hCAFE_F00D);
        chk("post.count", 32'(data_count), 32'd1);
        step("post", 1'b0, 1'b1, 32'h0);
        chk("post.data", d_out, 32'hCAFE_F00D);

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
            end else begin
                int sel;
                sel = $urandom_range(0, 9);
                step("rnd", sel < 5 || sel == 9, (sel >= 5), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
